env_unit_mc: RTL and testbench

- Parametrised multi-channel successor to the square/noise envelope unit: NUM_CH independent envelope generators sharing one CPU data bus and one quarter-frame tick.
- Envelope/volume width is generalised to VW bits, with an extension register supplying volume bits above bit 3.
- Each channel outputs its volume (constant or envelope) to the channel DAC mux, plus the length-counter enable (LC) to its length counter.

---
 rtl/env_pkg.sv | 25 ++
 rtl/env_channel.sv | 124 ++++++++++++
 rtl/env_unit_mc.sv | 60 ++++++
 tb/tb_env_unit_mc.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/env_pkg.sv
// rtl/env_pkg.sv - shared constants and register layout for the multi-channel envelope unit
// Purpose: CPU data-bus bit positions, elaboration limits and the per-channel
//          register struct used by env_channel.
// Ports:   none (package).
package env_pkg;

    // Control-register bit positions on the CPU data bus; VOL[3:0] sits in DB[3:0].
    localparam int DB_ENVDIS_BIT = 4;
    localparam int DB_HALT_BIT   = 5;
    localparam int DB_ATTACK_BIT = 6;

    // Elaboration limits for NUM_CH and VW.
    localparam int ENV_CH_MAX = 8;
    localparam int VW_MAX     = 8;

    // Per-channel control register. vol is sized for the widest build;
    // a channel only uses vol[VW-1:0], and the bits above stay at reset value.
    typedef struct packed {
        logic [VW_MAX-1:0] vol;
        logic              envdis;
        logic              halt;
        logic              attack;
    } env_reg_t;

endpackage

// File: rtl/env_channel.sv
// rtl/env_channel.sv - one envelope generator: control register, restart flag, divider, envelope counter
// Purpose: holds VOL/ENVDIS/HALT/ATTACK, the START flag, the VW-bit divider and
//          the VW-bit envelope counter for a single channel.
// Optional feature: ENV_ATTACK_EN enables the ATTACK bit and rising-envelope mode;
//          when undefined the channel is decay-only and DB[6] is ignored.
// Ports:
//   i_clk     - clock, all state updates on its rising edge
//   i_n_res   - synchronous active-low reset
//   i_tick    - quarter-frame tick (active high, one cycle per tick)
//   i_wr_reg  - control register write strobe
//   i_wr_ext  - volume-extension write strobe (no effect when VW=4)
//   i_wr_lc   - length-counter write strobe, arms the envelope restart
//   i_db      - CPU data bus
//   o_v       - channel volume (VOL when ENVDIS, else envelope)
//   o_lc      - length-counter enable (~HALT)
module env_channel
    import env_pkg::*;
#(
    parameter int VW = 4
) (
    input  logic          i_clk,
    input  logic          i_n_res,
    input  logic          i_tick,
    input  logic          i_wr_reg,
    input  logic          i_wr_ext,
    input  logic          i_wr_lc,
    input  logic [7:0]    i_db,
    output logic [VW-1:0] o_v,
    output logic          o_lc
);

    localparam logic [VW-1:0] ALL_ONES = {VW{1'b1}};
    localparam logic [VW-1:0] ONE      = VW'(1);

    env_reg_t      r_reg;
    env_reg_t      w_reg_next;
    logic          r_start;
    logic [VW-1:0] r_div;
    logic [VW-1:0] r_env;
    logic [VW-1:0] w_vol;
    logic [VW-1:0] w_env_step;
    logic          w_attack;
    logic          w_unused;

    assign w_vol = r_reg.vol[VW-1:0];

`ifdef ENV_ATTACK_EN
    assign w_attack = r_reg.attack;
`else
    assign w_attack = 1'b0;
`endif

    // Upper vol bits (VW < VW_MAX) and unused bus bits are intentionally dropped.
    assign w_unused = ^{r_reg, i_db};

    // Register writes are independent of each other and of the tick; the tick
    // path below reads r_reg, so it always sees the pre-write values.
    always_comb begin
        w_reg_next = r_reg;
        if (i_wr_reg) begin
            w_reg_next.vol[3:0] = i_db[3:0];
            w_reg_next.envdis   = i_db[DB_ENVDIS_BIT];
            w_reg_next.halt     = i_db[DB_HALT_BIT];
`ifdef ENV_ATTACK_EN
            w_reg_next.attack   = i_db[DB_ATTACK_BIT];
`endif
        end
        if (i_wr_ext) begin
            for (int b = 4; b < VW; b++) begin
                w_reg_next.vol[b] = i_db[b-4];
            end
        end
    end

    // One envelope step; HALT selects wrap-around versus hold at the end value.
    always_comb begin
        w_env_step = r_env;
        if (w_attack) begin
            if (r_env != ALL_ONES) begin
                w_env_step = r_env + ONE;
            end else if (r_reg.halt) begin
                w_env_step = '0;
            end
        end else begin
            if (r_env != '0) begin
                w_env_step = r_env - ONE;
            end else if (r_reg.halt) begin
                w_env_step = ALL_ONES;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_n_res) begin
            r_reg   <= '0;
            r_start <= 1'b0;
            r_div   <= '0;
            r_env   <= '0;
        end else begin
            r_reg <= w_reg_next;
            if (i_tick) begin
                if (r_start) begin
                    r_env   <= w_attack ? '0 : ALL_ONES;
                    r_div   <= w_vol;
                    r_start <= 1'b0;
                end else if (r_div == '0) begin
                    r_div <= w_vol;
                    r_env <= w_env_step;
                end else begin
                    r_div <= r_div - ONE;
                end
            end
            // Placed after the tick so a coinciding length write re-arms the
            // restart for the following tick rather than being consumed now.
            if (i_wr_lc) begin
                r_start <= 1'b1;
            end
        end
    end

    assign o_v  = r_reg.envdis ? w_vol : r_env;
    assign o_lc = ~r_reg.halt;

endmodule

// File: rtl/env_unit_mc.sv
// rtl/env_unit_mc.sv - NUM_CH envelope generators sharing one data bus and quarter-frame tick
// Purpose: top level; decodes the active-low tick and instantiates one
//          env_channel per channel, slicing the volume bus.
// Optional feature: ENV_ATTACK_EN (see env_channel) enables attack mode.
// Ports:
//   ACLK1  - APU clock
//   n_RES  - synchronous active-low reset
//   n_LFO1 - quarter-frame tick, active low
//   WR_Reg - per-channel control register write strobes
//   WR_Ext - per-channel volume-extension write strobes
//   WR_LC  - per-channel length-counter write strobes
//   DB     - CPU data bus, read only
//   V      - channel i volume at V[i*VW +: VW]
//   LC     - per-channel length-counter enable
module env_unit_mc
    import env_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int VW     = 4
) (
    input  logic                 ACLK1,
    input  logic                 n_RES,
    input  logic                 n_LFO1,
    input  logic [NUM_CH-1:0]    WR_Reg,
    input  logic [NUM_CH-1:0]    WR_Ext,
    input  logic [NUM_CH-1:0]    WR_LC,
    inout  wire  [7:0]           DB,
    output logic [NUM_CH*VW-1:0] V,
    output logic [NUM_CH-1:0]    LC
);

    if (NUM_CH < 1 || NUM_CH > ENV_CH_MAX) begin : g_bad_num_ch
        $error("env_unit_mc: NUM_CH out of range");
    end
    if (VW < 4 || VW > VW_MAX) begin : g_bad_vw
        $error("env_unit_mc: VW out of range");
    end

    logic w_tick;

    // Every low cycle is a tick; the frame counter keeps pulses to one cycle.
    assign w_tick = ~n_LFO1;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        env_channel #(
            .VW(VW)
        ) u_ch (
            .i_clk    (ACLK1),
            .i_n_res  (n_RES),
            .i_tick   (w_tick),
            .i_wr_reg (WR_Reg[i]),
            .i_wr_ext (WR_Ext[i]),
            .i_wr_lc  (WR_LC[i]),
            .i_db     (DB),
            .o_v      (V[i*VW +: VW]),
            .o_lc     (LC[i])
        );
    end

endmodule

// File: tb/tb_env_unit_mc.sv
// tb/tb_env_unit_mc.sv - directed self-checking bench for env_unit_mc (VW=4 and VW=6 instances)
module tb_env_unit_mc;

    logic        clk;
    logic        n_res;
    logic        n_lfo1;
    logic [1:0]  wr_reg;
    logic [1:0]  wr_ext;
    logic [1:0]  wr_lc;
    logic [7:0]  r_db;
    wire  [7:0]  db;
    logic [7:0]  v4;
    logic [11:0] v6;
    logic [1:0]  lc4;
    logic [1:0]  lc6;
    int          checks;
    int          errors;
    int          exp_v;

    assign db = r_db;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    env_unit_mc #(.NUM_CH(2), .VW(4)) dut4 (
        .ACLK1(clk), .n_RES(n_res), .n_LFO1(n_lfo1),
        .WR_Reg(wr_reg), .WR_Ext(wr_ext), .WR_LC(wr_lc),
        .DB(db), .V(v4), .LC(lc4)
    );

    env_unit_mc #(.NUM_CH(2), .VW(6)) dut6 (
        .ACLK1(clk), .n_RES(n_res), .n_LFO1(n_lfo1),
        .WR_Reg(wr_reg), .WR_Ext(wr_ext), .WR_LC(wr_lc),
        .DB(db), .V(v6), .LC(lc6)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        n_lfo1 = 1'b0;
        step();
        n_lfo1 = 1'b1;
    endtask

    task automatic write(input logic [1:0] r, input logic [1:0] e, input logic [1:0] l,
                         input logic [7:0] d);
        wr_reg = r;
        wr_ext = e;
        wr_lc  = l;
        r_db   = d;
        step();
        wr_reg = 2'b00;
        wr_ext = 2'b00;
        wr_lc  = 2'b00;
        r_db   = 8'h00;
    endtask

    task automatic do_reset();
        n_res  = 1'b0;
        wr_reg = 2'b11;
        wr_ext = 2'b11;
        wr_lc  = 2'b11;
        r_db   = 8'hFF;
        n_lfo1 = 1'b0;
        repeat (3) step();
        n_res  = 1'b1;
        wr_reg = 2'b00;
        wr_ext = 2'b00;
        wr_lc  = 2'b00;
        r_db   = 8'h00;
        n_lfo1 = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        n_res  = 1'b0;
        n_lfo1 = 1'b1;
        wr_reg = 2'b00;
        wr_ext = 2'b00;
        wr_lc  = 2'b00;
        r_db   = 8'h00;

        // Reset with every strobe and the tick active
        do_reset();
        check("rst_v4", 32'(v4), 0);
        check("rst_v6", 32'(v6), 0);
        check("rst_lc4", 32'(lc4), 3);
        check("rst_lc6", 32'(lc6), 3);
        tick();
        check("rst_tick_v4", 32'(v4), 0);
        check("rst_tick_v6", 32'(v6), 0);

        // Decay, VOL=2: step every 3 ticks, 15 at tick 1, 0 at tick 46
        write(2'b01, 2'b00, 2'b00, 8'h02);
        write(2'b00, 2'b00, 2'b01, 8'h00);
        for (int k = 1; k <= 50; k++) begin
            tick();
            case (k)
                1:  check("decay_t1", 32'(v4[3:0]), 15);
                4:  check("decay_t4", 32'(v4[3:0]), 14);
                7:  check("decay_t7", 32'(v4[3:0]), 13);
                45: check("decay_t45", 32'(v4[3:0]), 1);
                46: check("decay_t46", 32'(v4[3:0]), 0);
                50: check("decay_t50", 32'(v4[3:0]), 0);
                default: ;
            endcase
        end
        check("decay_v1", 32'(v4[7:4]), 0);

        // Looping decay, VOL=0, HALT=1
        do_reset();
        write(2'b01, 2'b00, 2'b00, 8'h20);
        check("loop_lc", 32'(lc4), 2);
        write(2'b00, 2'b00, 2'b01, 8'h00);
        for (int k = 1; k <= 17; k++) begin
            tick();
            exp_v = (16 - k) & 15;
            check("loop_v0", 32'(v4[3:0]), 32'(exp_v));
        end

        // Constant volume with extension bits (VW=6)
        do_reset();
        write(2'b01, 2'b00, 2'b00, 8'h1A);
        write(2'b00, 2'b01, 2'b00, 8'h02);
        check("ext_v6", 32'(v6[5:0]), 32'h2A);
        check("ext_v4", 32'(v4[3:0]), 32'hA);
        write(2'b00, 2'b00, 2'b01, 8'h00);
        tick();
        check("ext_const_v6", 32'(v6[5:0]), 32'h2A);
        write(2'b01, 2'b00, 2'b00, 8'h0A);
        check("ext_env_v6", 32'(v6[5:0]), 63);
        check("ext_env_v4", 32'(v4[3:0]), 15);
        check("ext_v6_ch1", 32'(v6[11:6]), 0);

        // WR_LC coinciding with a tick while ENV=5
        do_reset();
        write(2'b01, 2'b00, 2'b00, 8'h00);
        write(2'b00, 2'b00, 2'b01, 8'h00);
        repeat (11) tick();
        check("coll_pre", 32'(v4[3:0]), 5);
        wr_lc  = 2'b01;
        n_lfo1 = 1'b0;
        step();
        wr_lc  = 2'b00;
        n_lfo1 = 1'b1;
        check("coll_same", 32'(v4[3:0]), 4);
        tick();
        check("coll_restart", 32'(v4[3:0]), 15);

        // WR_Reg coinciding with a tick: the tick uses the old VOL=0
        wr_reg = 2'b01;
        r_db   = 8'h05;
        n_lfo1 = 1'b0;
        step();
        wr_reg = 2'b00;
        r_db   = 8'h00;
        n_lfo1 = 1'b1;
        check("regcoll_t1", 32'(v4[3:0]), 14);
        tick();
        check("regcoll_t2", 32'(v4[3:0]), 13);
        tick();
        check("regcoll_t3", 32'(v4[3:0]), 13);

        // ATTACK=1, VOL=0, HALT=0
        do_reset();
        write(2'b01, 2'b00, 2'b00, 8'h40);
        check("att_lc", 32'(lc4), 3);
        write(2'b00, 2'b00, 2'b01, 8'h00);
        for (int k = 1; k <= 17; k++) begin
            tick();
`ifdef ENV_ATTACK_EN
            exp_v = (k > 16) ? 15 : k - 1;
`else
            exp_v = (k > 16) ? 0 : 16 - k;
`endif
            check("attack_v0", 32'(v4[3:0]), 32'(exp_v));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
